// File: rtl/lcd_bus_scheduler.sv
// HD44780 bus engine: runs the 8-bit power-on init, then serves two
// req/ack writers with round-robin arbitration and counter-based bus timing.
`timescale 1ns/1ps
module lcd_bus_scheduler #(
    parameter int unsigned T_PWRUP = 5000,
    parameter int unsigned T_INIT1 = 205000,
    parameter int unsigned T_INIT2 = 5000,
    parameter int unsigned T_SETUP = 2,
    parameter int unsigned T_EN    = 25,
    parameter int unsigned T_HOLD  = 2,
    parameter int unsigned T_SHORT = 2650,
    parameter int unsigned T_LONG  = 150000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic       rs_a,
    input  logic [7:0] data_a,
    input  logic       req_b,
    input  logic       rs_b,
    input  logic [7:0] data_b,
    output logic       ack_a,
    output logic       ack_b,
    output logic       init_done,
    output logic       busy,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA
);

    localparam int unsigned CNT_W = 24;
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] INIT_LEN = IDX_W'(8);

    function automatic logic [CNT_W-1:0] clamp_cnt(input int unsigned t);
        return (t == 0) ? CNT_W'(1) : CNT_W'(t);
    endfunction

    localparam logic [CNT_W-1:0] C_PWRUP = clamp_cnt(T_PWRUP);
    localparam logic [CNT_W-1:0] C_INIT1 = clamp_cnt(T_INIT1);
    localparam logic [CNT_W-1:0] C_INIT2 = clamp_cnt(T_INIT2);
    localparam logic [CNT_W-1:0] C_SETUP = clamp_cnt(T_SETUP);
    localparam logic [CNT_W-1:0] C_EN    = clamp_cnt(T_EN);
    localparam logic [CNT_W-1:0] C_HOLD  = clamp_cnt(T_HOLD);
    localparam logic [CNT_W-1:0] C_SHORT = clamp_cnt(T_SHORT);
    localparam logic [CNT_W-1:0] C_LONG  = clamp_cnt(T_LONG);

    typedef enum logic [2:0] {
        S_PWRUP, S_INIT_LOAD, S_SETUP, S_EN_HI, S_HOLD, S_WAIT, S_IDLE
    } state_t;

    typedef enum logic {GRANT_A, GRANT_B} grant_t;

    // Init table entry: {byte, post-write wait}
    function automatic logic [8+CNT_W-1:0] init_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    return {8'h30, C_INIT1};
            3'd1:    return {8'h30, C_INIT2};
            3'd2:    return {8'h30, C_SHORT};
            3'd3:    return {8'h38, C_SHORT};
            3'd4:    return {8'h08, C_SHORT};
            3'd5:    return {8'h01, C_LONG};
            3'd6:    return {8'h06, C_SHORT};
            default: return {8'h0C, C_SHORT};
        endcase
    endfunction

    // Clear (0x01) and home (0x02/0x03) need the long execution time
    function automatic logic [CNT_W-1:0] user_wait(input logic rs, input logic [7:0] d);
        return (!rs && d[7:2] == 6'd0 && d != 8'd0) ? C_LONG : C_SHORT;
    endfunction

    state_t             state, state_nxt;
    grant_t             last_grant, lg_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_nxt;
    logic [IDX_W-1:0]   init_idx, idx_nxt;
    logic               rs_nxt, en_nxt, ack_a_nxt, ack_b_nxt, done_nxt, busy_nxt;
    logic [7:0]         data_nxt;
    logic               take_a, take_b;

    assign LCD_RW = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_PWRUP;
            cnt        <= C_PWRUP;
            wait_cnt   <= C_SHORT;
            init_idx   <= '0;
            last_grant <= GRANT_B;
            LCD_RS     <= 1'b0;
            LCD_EN     <= 1'b0;
            LCD_DATA   <= 8'h00;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            init_done  <= 1'b0;
            busy       <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wait_cnt   <= wait_nxt;
            init_idx   <= idx_nxt;
            last_grant <= lg_nxt;
            LCD_RS     <= rs_nxt;
            LCD_EN     <= en_nxt;
            LCD_DATA   <= data_nxt;
            ack_a      <= ack_a_nxt;
            ack_b      <= ack_b_nxt;
            init_done  <= done_nxt;
            busy       <= busy_nxt;
        end
    end

    // Next-state, counter and registered-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        wait_nxt  = wait_cnt;
        idx_nxt   = init_idx;
        lg_nxt    = last_grant;
        rs_nxt    = LCD_RS;
        data_nxt  = LCD_DATA;
        ack_a_nxt = 1'b0;
        ack_b_nxt = 1'b0;
        done_nxt  = init_done;
        take_a    = 1'b0;
        take_b    = 1'b0;

        case (state)
            S_PWRUP: begin
                if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
                else                 state_nxt = S_INIT_LOAD;
            end
            S_INIT_LOAD: begin
                {data_nxt, wait_nxt} = init_entry(init_idx[2:0]);
                rs_nxt    = 1'b0;
                idx_nxt   = init_idx + IDX_W'(1);
                cnt_nxt   = C_SETUP;
                state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
                else begin
                    cnt_nxt   = C_EN;
                    state_nxt = S_EN_HI;
                end
            end
            S_EN_HI: begin
                if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
                else begin
                    cnt_nxt   = C_HOLD;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
                else begin
                    cnt_nxt   = wait_cnt;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt > CNT_W'(1)) cnt_nxt = cnt - CNT_W'(1);
                else if (init_done || init_idx == INIT_LEN) begin
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt = S_INIT_LOAD;
                end
            end
            S_IDLE: begin
                // On contention the requester not served last wins
                take_a = init_done && req_a && (!req_b || last_grant == GRANT_B);
                take_b = init_done && req_b && !take_a;
                if (take_a || take_b) begin
                    rs_nxt    = take_a ? rs_a : rs_b;
                    data_nxt  = take_a ? data_a : data_b;
                    wait_nxt  = user_wait(rs_nxt, data_nxt);
                    ack_a_nxt = take_a;
                    ack_b_nxt = take_b;
                    lg_nxt    = take_a ? GRANT_A : GRANT_B;
                    cnt_nxt   = C_SETUP;
                    state_nxt = S_SETUP;
                end
            end
            default: begin
                state_nxt = S_PWRUP;
                cnt_nxt   = C_PWRUP;
            end
        endcase

        en_nxt   = (state_nxt == S_EN_HI);
        busy_nxt = (state_nxt != S_IDLE);
    end

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler: init sequence, arbitration, wait
// selection, bus setup/hold and asynchronous reset mid-pulse.
`timescale 1ns/1ps
module tb_lcd_bus_scheduler;

    localparam int unsigned P_PWRUP = 10;
    localparam int unsigned P_INIT1 = 50;
    localparam int unsigned P_INIT2 = 30;
    localparam int unsigned P_SETUP = 2;
    localparam int unsigned P_EN    = 4;
    localparam int unsigned P_HOLD  = 2;
    localparam int unsigned P_SHORT = 20;
    localparam int unsigned P_LONG  = 100;

    logic       clk, rst_n;
    logic       req_a, rs_a, req_b, rs_b;
    logic [7:0] data_a, data_b;
    logic       ack_a, ack_b, init_done, busy;
    logic       LCD_RS, LCD_RW, LCD_EN;
    logic [7:0] LCD_DATA;

    int n_checks = 0;
    int n_pass   = 0;

    lcd_bus_scheduler #(
        .T_PWRUP(P_PWRUP), .T_INIT1(P_INIT1), .T_INIT2(P_INIT2),
        .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD),
        .T_SHORT(P_SHORT), .T_LONG(P_LONG)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .rs_a(rs_a), .data_a(data_a),
        .req_b(req_b), .rs_b(rs_b), .data_b(data_b),
        .ack_a(ack_a), .ack_b(ack_b), .init_done(init_done), .busy(busy),
        .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN), .LCD_DATA(LCD_DATA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus monitor, sampled on the falling edge
    int         cyc = 0;
    logic [7:0] pdata[$];
    bit         prs[$];
    int         pwid[$], prise[$], ack_a_q[$], ack_b_q[$], bfall[$], done_rise[$];
    int         setup_bad = 0, hold_bad = 0, rw_bad = 0, early_ack = 0;
    logic       prev_en, prev_busy, prev_done;
    logic [8:0] prev_rd, pulse_rd, cur_rd;
    int         stable, hold_left, width;

    initial begin
        prev_en = 0; prev_busy = 1; prev_done = 0; prev_rd = '0; pulse_rd = '0;
        stable = 0; hold_left = 0; width = 0;
        forever begin
            @(negedge clk);
            cyc++;
            cur_rd = {LCD_RS, LCD_DATA};
            if (LCD_RW !== 1'b0) rw_bad++;
            if (!rst_n) begin
                prev_en = 0; prev_busy = 1; prev_done = 0; hold_left = 0; stable = 0;
                prev_rd = cur_rd;
            end else begin
                stable  = (cur_rd === prev_rd) ? stable + 1 : 1;
                prev_rd = cur_rd;
                if (LCD_EN && !prev_en) begin
                    pulse_rd = cur_rd;
                    width    = 1;
                    if (stable < int'(P_SETUP) + 1) setup_bad++;
                    pdata.push_back(LCD_DATA);
                    prs.push_back(LCD_RS);
                    prise.push_back(cyc);
                end else if (LCD_EN) begin
                    width++;
                    if (cur_rd !== pulse_rd) hold_bad++;
                end else if (prev_en) begin
                    pwid.push_back(width);
                    hold_left = int'(P_HOLD);
                end
                if (!LCD_EN && hold_left > 0) begin
                    if (cur_rd !== pulse_rd) hold_bad++;
                    hold_left--;
                end
                if (ack_a) ack_a_q.push_back(cyc);
                if (ack_b) ack_b_q.push_back(cyc);
                if ((ack_a || ack_b) && !init_done) early_ack++;
                if (prev_busy && !busy) bfall.push_back(cyc);
                if (init_done && !prev_done) done_rise.push_back(cyc);
                prev_en = LCD_EN; prev_busy = busy; prev_done = init_done;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        pdata.delete(); prs.delete(); pwid.delete(); prise.delete();
        ack_a_q.delete(); ack_b_q.delete(); bfall.delete(); done_rise.delete();
        early_ack = 0;
    endtask

    // Drops each req once acked, returns when both are served and the bus is idle
    task automatic serve(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (ack_a) req_a = 0;
            if (ack_b) req_b = 0;
            if (!req_a && !req_b && !busy) begin ok = 1; break; end
        end
    endtask

    task automatic test_reset();
        rst_n = 0; req_a = 0; req_b = 0; rs_a = 0; rs_b = 0; data_a = 0; data_b = 0;
        repeat (3) @(negedge clk); #1;
        n_checks++; if (LCD_RS !== 1'b0) $display("FAIL reset_rs: got %b want 0", LCD_RS); else n_pass++;
        n_checks++; if (LCD_RW !== 1'b0) $display("FAIL reset_rw: got %b want 0", LCD_RW); else n_pass++;
        n_checks++; if (LCD_EN !== 1'b0) $display("FAIL reset_en: got %b want 0", LCD_EN); else n_pass++;
        n_checks++; if (LCD_DATA !== 8'h00) $display("FAIL reset_data: got %h want 00", LCD_DATA); else n_pass++;
        n_checks++; if ({ack_a, ack_b} !== 2'b00) $display("FAIL reset_ack: got %b want 00", {ack_a, ack_b}); else n_pass++;
        n_checks++; if (init_done !== 1'b0) $display("FAIL reset_init_done: got %b want 0", init_done); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
    endtask

    task automatic test_init_sequence(input bit early);
        logic [7:0] exp_byte[8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
        int         exp_gap[7]  = '{59, 39, 29, 29, 29, 109, 29};
        int         c0;
        bit         ok;
        clear_logs();
        @(negedge clk); #1;
        c0 = cyc;
        rst_n = 1;
        if (early) begin
            repeat (20) @(negedge clk);
            #1; rs_a = 1; data_a = 8'h41; req_a = 1;
        end
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (init_done) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        n_checks++; if (!ok) $display("FAIL init_timeout: init_done %b want 1 within 1000 cycles", init_done); else n_pass++;
        n_checks++; if (pdata.size() != 8) $display("FAIL init_pulse_count: got %0d want 8", pdata.size()); else n_pass++;
        if (pdata.size() >= 8 && pwid.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                n_checks++; if (pdata[k] !== exp_byte[k]) $display("FAIL init_byte[%0d]: got %h want %h", k, pdata[k], exp_byte[k]); else n_pass++;
                n_checks++; if (prs[k] !== 1'b0) $display("FAIL init_rs[%0d]: got %b want 0", k, prs[k]); else n_pass++;
                n_checks++; if (pwid[k] != int'(P_EN)) $display("FAIL init_width[%0d]: got %0d want %0d", k, pwid[k], P_EN); else n_pass++;
            end
            for (int k = 0; k < 7; k++) begin
                n_checks++; if (prise[k+1] - prise[k] != exp_gap[k]) $display("FAIL init_gap[%0d]: got %0d want %0d", k, prise[k+1] - prise[k], exp_gap[k]); else n_pass++;
            end
            n_checks++; if (prise[0] - c0 != 13) $display("FAIL init_first_rise: got %0d want 13", prise[0] - c0); else n_pass++;
        end
        if (done_rise.size() > 0) begin
            n_checks++; if (done_rise[0] - c0 != 362) $display("FAIL init_duration: got %0d want 362", done_rise[0] - c0); else n_pass++;
        end
        n_checks++; if (early_ack != 0) $display("FAIL early_ack: got %0d acks before init_done want 0", early_ack); else n_pass++;
        if (early && done_rise.size() > 0) begin
            ok = 0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk); #1;
                if (ack_a) begin ok = 1; req_a = 0; break; end
            end
            n_checks++; if (!ok) $display("FAIL early_ack_timeout: ack_a %b want 1 within 10 cycles", ack_a); else n_pass++;
            n_checks++; if (ack_a_q.size() != 1 || ack_a_q[0] - done_rise[0] != 1)
                $display("FAIL early_ack_latency: got %0d acks, latency %0d want 1 ack, latency 1", ack_a_q.size(), (ack_a_q.size() > 0) ? ack_a_q[0] - done_rise[0] : -1);
            else n_pass++;
            @(negedge clk); #1;
            n_checks++; if (ack_a !== 1'b0) $display("FAIL ack_one_cycle: got %b want 0", ack_a); else n_pass++;
            ok = 0;
            for (int i = 0; i < 100; i++) begin
                if (!busy) begin ok = 1; break; end
                @(negedge clk); #1;
            end
            n_checks++; if (!ok || pdata.size() != 9) $display("FAIL early_write_done: idle %b pulses %0d want 1 and 9", ok, pdata.size()); else n_pass++;
            if (pdata.size() >= 9 && pwid.size() >= 9) begin
                n_checks++; if (pdata[8] !== 8'h41) $display("FAIL early_byte: got %h want 41", pdata[8]); else n_pass++;
                n_checks++; if (prs[8] !== 1'b1) $display("FAIL early_rs: got %b want 1", prs[8]); else n_pass++;
                n_checks++; if (pwid[8] != int'(P_EN)) $display("FAIL early_width: got %0d want %0d", pwid[8], P_EN); else n_pass++;
                n_checks++; if (bfall[bfall.size()-1] - prise[8] != 26) $display("FAIL early_wait: got %0d want 26", bfall[bfall.size()-1] - prise[8]); else n_pass++;
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        clear_logs();
        rs_a = 1; data_a = 8'h41; rs_b = 1; data_b = 8'h42; req_a = 1; req_b = 1;
        serve(200, ok);
        n_checks++; if (!ok) $display("FAIL sim_timeout: req_a %b req_b %b busy %b want all 0", req_a, req_b, busy); else n_pass++;
        n_checks++; if (ack_a_q.size() != 1 || ack_b_q.size() != 1) $display("FAIL sim_ack_count: got a=%0d b=%0d want 1 and 1", ack_a_q.size(), ack_b_q.size()); else n_pass++;
        if (ack_a_q.size() > 0 && ack_b_q.size() > 0) begin
            n_checks++; if (ack_b_q[0] - ack_a_q[0] != 29) $display("FAIL sim_ack_spacing: got %0d want 29", ack_b_q[0] - ack_a_q[0]); else n_pass++;
        end
        if (pdata.size() >= 2) begin
            n_checks++; if (pdata[0] !== 8'h41 || pdata[1] !== 8'h42) $display("FAIL sim_order: got %h,%h want 41,42", pdata[0], pdata[1]); else n_pass++;
        end
        clear_logs();
        data_a = 8'h43; data_b = 8'h44; req_a = 1; req_b = 1;
        serve(200, ok);
        n_checks++; if (!ok) $display("FAIL sim2_timeout: busy %b want 0", busy); else n_pass++;
        if (ack_a_q.size() > 0 && ack_b_q.size() > 0) begin
            n_checks++; if (!(ack_a_q[0] < ack_b_q[0])) $display("FAIL sim2_winner: ack_a at %0d ack_b at %0d want A first", ack_a_q[0], ack_b_q[0]); else n_pass++;
        end
        if (pdata.size() >= 1) begin
            n_checks++; if (pdata[0] !== 8'h43) $display("FAIL sim2_first_byte: got %h want 43", pdata[0]); else n_pass++;
        end
    endtask

    task automatic test_clear_command();
        bit         ct_rs[6]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] ct_data[6] = '{8'h01, 8'h0C, 8'h02, 8'h01, 8'h04, 8'h00};
        int         ct_wait[6] = '{100, 20, 100, 20, 20, 20};
        bit         ok;
        for (int k = 0; k < 6; k++) begin
            clear_logs();
            if (k % 2 == 0) begin rs_b = ct_rs[k]; data_b = ct_data[k]; req_b = 1; end
            else            begin rs_a = ct_rs[k]; data_a = ct_data[k]; req_a = 1; end
            serve(400, ok);
            n_checks++; if (!ok || pdata.size() != 1) $display("FAIL cmd[%0d]_done: idle %b pulses %0d want 1 and 1", k, ok, pdata.size()); else n_pass++;
            if (pdata.size() >= 1 && bfall.size() >= 1) begin
                n_checks++; if (pdata[0] !== ct_data[k] || prs[0] !== ct_rs[k]) $display("FAIL cmd[%0d]_bus: got rs=%b %h want rs=%b %h", k, prs[0], pdata[0], ct_rs[k], ct_data[k]); else n_pass++;
                n_checks++; if (bfall.size() != 1 || bfall[0] - prise[0] != int'(P_EN + P_HOLD) + ct_wait[k])
                    $display("FAIL cmd[%0d]_wait: got %0d busy falls, rise-to-idle %0d want 1, %0d", k, bfall.size(), bfall[0] - prise[0], int'(P_EN + P_HOLD) + ct_wait[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        bit ok = 0;
        rs_a = 1; data_a = 8'h55; req_a = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (ack_a) req_a = 0;
            if (LCD_EN) begin ok = 1; break; end
        end
        n_checks++; if (!ok) $display("FAIL midrst_no_pulse: LCD_EN %b want 1 within 100 cycles", LCD_EN); else n_pass++;
        #1 rst_n = 0;
        #1;
        n_checks++; if (LCD_EN !== 1'b0) $display("FAIL midrst_en: got %b want 0", LCD_EN); else n_pass++;
        n_checks++; if (LCD_RS !== 1'b0 || LCD_DATA !== 8'h00) $display("FAIL midrst_bus: got rs=%b %h want rs=0 00", LCD_RS, LCD_DATA); else n_pass++;
        n_checks++; if (init_done !== 1'b0 || busy !== 1'b1) $display("FAIL midrst_status: got done=%b busy=%b want 0 1", init_done, busy); else n_pass++;
        n_checks++; if ({ack_a, ack_b} !== 2'b00) $display("FAIL midrst_ack: got %b want 00", {ack_a, ack_b}); else n_pass++;
        req_a = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_protocol();
        n_checks++; if (setup_bad != 0) $display("FAIL setup_stability: got %0d violations want 0", setup_bad); else n_pass++;
        n_checks++; if (hold_bad != 0) $display("FAIL hold_stability: got %0d violations want 0", hold_bad); else n_pass++;
        n_checks++; if (rw_bad != 0) $display("FAIL rw_low: got %0d samples with RW!=0 want 0", rw_bad); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_init_sequence(1'b0);
        test_simultaneous();
        test_clear_command();
        test_reset_mid_pulse();
        test_init_sequence(1'b1);
        test_protocol();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_scheduler.md
# lcd_bus_scheduler

Clocked HD44780 bus engine that owns the character LCD pins (LCD_RS, LCD_RW, LCD_EN, LCD_DATA). After reset it autonomously runs the 8-bit power-on initialisation sequence. It then shares the LCD between two requesters (for example, the CRC digit writer and a status/message writer) through req/ack handshakes with round-robin arbitration. It generates setup, enable-pulse, hold and post-command wait timing from cycle counters, with no `#` delays.

## Interface
- T_PWRUP, 5000: cycles from reset release to the first init write (100 µs at 50 MHz).
- T_INIT1, 205000: wait after the first 0x30 write (4.1 ms).
- T_INIT2, 5000: wait after the second 0x30 write (100 µs).
- T_SETUP, 2: cycles RS/DATA are stable before EN rises.
- T_EN, 25: EN high width, in cycles.
- T_HOLD, 2: cycles RS/DATA are held after EN falls.
- T_SHORT, 2650: post-write wait for normal commands and data (53 µs).
- T_LONG, 150000: post-write wait for clear/home (3 ms).
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_a / req_b  in  1  write request, level; held until acked.
- rs_a / rs_b  in  1  register select for the request (0 = command, 1 = data).
- data_a / data_b  in  8  byte to write.
- ack_a / ack_b  out  1  one-cycle pulse; the request is captured on that edge.
- init_done  out  1  sticky high once initialisation completes.
- busy  out  1  high in every state except IDLE.
- LCD_RS  out  1  to the panel.
- LCD_RW  out  1  to the panel; tied 0 (write-only).
- LCD_EN  out  1  to the panel.
- LCD_DATA  out  8  to the panel.

## Operation
- Reset values: LCD_RS=0, LCD_RW=0, LCD_EN=0, LCD_DATA=0x00, ack_a=ack_b=0, init_done=0, busy=1. State is PWRUP, the counter is loaded with T_PWRUP, and init_idx=0 and last_grant=B.
- States:
  - PWRUP → INIT_LOAD.
  - INIT_LOAD → SETUP.
  - SETUP → EN_HI → HOLD → WAIT.
  - WAIT → INIT_LOAD, or IDLE when the init table is exhausted or a user write is in progress.
  - IDLE → SETUP on grant.
- Init table (all RS=0), with the wait after each entry:
  - 0x30 (T_INIT1)
  - 0x30 (T_INIT2)
  - 0x30 (T_SHORT)
  - 0x38 (T_SHORT)
  - 0x08 (T_SHORT)
  - 0x01 (T_LONG)
  - 0x06 (T_SHORT)
  - 0x0C (T_SHORT)
- init_done is set on the edge leaving the last WAIT into IDLE. Requests are ignored and no ack is issued before that edge.
- Arbitration runs in IDLE only:
  - If only one req is high, that requester is granted.
  - If both are high, the requester not in last_grant is granted.
  - A grant pulses the matching ack, latches rs/data into LCD_RS/LCD_DATA on the same edge, updates last_grant, and moves to SETUP.
- Wait selection for user writes: T_LONG when rs=0 and data[7:2]==0 and data!=0 (clear 0x01, home 0x02/0x03). Otherwise T_SHORT.
- LCD_RS and LCD_DATA stay unchanged from SETUP entry through the end of WAIT. They hold their last value in IDLE.
- A request that drops before being acked is simply not served. A requester holding req high after its ack is treated as a new request.
- Asserting rst_n low at any point, including mid-EN pulse, immediately forces the reset values (LCD_EN=0). The full init sequence then re-runs.

## Timing
- SETUP lasts T_SETUP cycles with EN=0. EN_HI lasts T_EN cycles with EN=1. HOLD lasts T_HOLD cycles with EN=0. WAIT lasts the selected wait count.
- One user write occupies 1 (grant) + T_SETUP + T_EN + T_HOLD + Twait cycles. The earliest next ack comes in the first IDLE cycle after that.
- Grant latency: an ack is asserted in the first IDLE cycle in which req is sampled high, so back-to-back requests have no gap beyond the write time.
- Counters are 24 bits wide. Each phase loads N and counts down to 1, so exactly N cycles pass. A parameter of 0 is treated as 1.
- Init duration: T_PWRUP + 8×(T_SETUP+T_EN+T_HOLD) + the sum of the table waits, +8 cycles for the INIT_LOAD states.

## Test plan
- Init sequence: reset with T_PWRUP=10, T_SETUP=2, T_EN=4, T_HOLD=2, T_SHORT=20, T_LONG=100, T_INIT1=50, T_INIT2=30 → exactly 8 EN pulses with bytes 30,30,30,38,08,01,06,0C and RS=0; each pulse is 4 cycles wide; init_done rises after the final wait.
- Early request: req_a=1 with data 0x41 during init → no ack_a until init_done; then a single write 0x41 with RS=1 followed by a T_SHORT (20-cycle) wait.
- Simultaneous requests: req_a and req_b both high in IDLE (A: RS=1 'A', B: RS=1 'B'), last_grant=B → ack_a first, then ack_b after 1+2+4+2+20=29 cycles; the next contention goes to A.
- Clear command: rs_b=0, data_b=0x01 → T_LONG (100-cycle) wait and busy held high; then write 0x0C → T_SHORT.
- Setup/hold check: for every EN pulse, LCD_DATA and LCD_RS are stable for ≥2 cycles before EN rises and ≥2 cycles after it falls; LCD_RW is 0 throughout.
- Reset mid-pulse: rst_n low during EN_HI → LCD_EN=0 in the same cycle with no clock, all outputs return to their reset values, and the init sequence repeats in full.
